// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES = 2;
  localparam int BYTE_W    = 8;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects stream bytes into little-endian words; flags the accept that completes a word.
module loader_word_assembler
  import instr_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WIDTH-1:0]  word,
  output logic              word_valid
);

  localparam int LANES = WIDTH / BYTE_W;

  logic [1:0] lane_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt_reg <= '0;
    end else if (clear) begin
      lane_cnt_reg <= '0;
    end else if (accept) begin
      lane_cnt_reg <= lane_cnt_reg + 2'd1;
    end
  end

  // Lower lanes are stored; the top lane is taken straight from the completing byte.
  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : lane_g
      logic [BYTE_W-1:0] lane_byte_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_byte_reg <= '0;
        end else if (accept && lane_cnt_reg == 2'(gi)) begin
          lane_byte_reg <= byte_in;
        end
      end

      assign word[gi*BYTE_W +: BYTE_W] = lane_byte_reg;
    end
  endgenerate

  assign word[WIDTH-1 -: BYTE_W] = byte_in;
  assign word_valid = accept && (lane_cnt_reg == 2'(LANES - 1));

endmodule

// File: rtl/instr_loader.sv
// Streams a checksummed program image into instruction memory and gates processor reset.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int SIZE    = 64,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [WIDTH-1:0]     instr_in,
  output logic [LOGSIZE+1:0]   instr_wr_addr,
  output logic                 instr_wr_en,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int HDR_W = HDR_BYTES * BYTE_W;
  localparam logic [HDR_W-1:0] SIZE_N = HDR_W'(SIZE);

  loader_state_t      state_reg, state_next;
  logic [HDR_W-1:0]   n_reg, n_next;
  logic [BYTE_W-1:0]  chk_reg, chk_next;
  logic [LOGSIZE:0]   word_cnt_reg, word_cnt_next;
  logic [HDR_W-1:0]   hdr_n;
  logic               handshake;
  logic               load_start;
  logic [WIDTH-1:0]   word;
  logic               word_valid;

  assign handshake  = byte_valid && byte_ready;
  assign load_start = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
  assign hdr_n      = {byte_in, n_reg[BYTE_W-1:0]};

  loader_word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .accept     (handshake && state_reg == DATA),
    .byte_in    (byte_in),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    chk_next      = chk_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = HDR_LO;
          chk_next      = '0;
          word_cnt_next = '0;
        end
      end
      HDR_LO: begin
        if (handshake) begin
          n_next[BYTE_W-1:0] = byte_in;
          chk_next           = chk_reg ^ byte_in;
          state_next         = HDR_HI;
        end
      end
      HDR_HI: begin
        if (handshake) begin
          n_next     = hdr_n;
          chk_next   = chk_reg ^ byte_in;
          state_next = (hdr_n != '0 && hdr_n <= SIZE_N) ? DATA : ERR;
        end
      end
      DATA: begin
        if (handshake) begin
          chk_next = chk_reg ^ byte_in;
          if (word_valid) begin
            word_cnt_next = word_cnt_reg + 1'b1;
            // Counter is zero-extended so N=SIZE compares correctly.
            if (HDR_W'(word_cnt_reg) + HDR_W'(1) == n_reg) begin
              state_next = CHK;
            end
          end
        end
      end
      CHK: begin
        if (handshake) begin
          state_next = (byte_in == chk_reg) ? DONE : ERR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      n_reg         <= '0;
      chk_reg       <= '0;
      word_cnt_reg  <= '0;
      byte_ready    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      cpu_reset     <= 1'b1;
      instr_wr_en   <= 1'b0;
      instr_in      <= '0;
      instr_wr_addr <= '0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      chk_reg      <= chk_next;
      word_cnt_reg <= word_cnt_next;
      // Status flags follow the upcoming state so they are registered yet current.
      byte_ready   <= accepts_bytes(state_next);
      busy         <= accepts_bytes(state_next);
      done         <= (state_next == DONE);
      error        <= (state_next == ERR);
      cpu_reset    <= (state_next != DONE);
      instr_wr_en  <= word_valid;
      if (word_valid) begin
        instr_in      <= word;
        instr_wr_addr <= {word_cnt_reg[LOGSIZE-1:0], 2'b00};
      end
    end
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader that writes the processor's instruction memory through its write port (`instr_in`, `instr_wr_addr`, `instr_wr_en`). It takes a byte stream with a valid/ready handshake, checks a word-count header, assembles little-endian 32-bit words, writes them to consecutive word addresses and validates an XOR checksum trailer. It holds the processor in reset until a load completes cleanly. It sits between the host/UART byte source and the processor top.

## Interface
- `WIDTH`, 32, bits per instruction word; fixed at 32.
- `SIZE`, 64, instruction memory depth in words; must match the processor's `SIZE`.
- `LOGSIZE`, $clog2(SIZE), localparam.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `instr_in`  out  WIDTH  word to write; drives the processor's `instr_in`.
- `instr_wr_addr`  out  LOGSIZE+2  byte address, always a multiple of 4.
- `instr_wr_en`  out  1  one-cycle write strobe.
- `cpu_reset`  out  1  holds the processor in reset; low only in DONE.
- `busy`  out  1  load in progress.
- `done`  out  1  last load succeeded.
- `error`  out  1  last load failed (bad header or bad checksum).

## Operation
- A handshake occurs when `byte_valid && byte_ready`.
- `byte_ready` is 1 in HDR_LO, HDR_HI, DATA and CHK, and 0 elsewhere.
- Stream format:
  - N[7:0], then N[15:8];
  - then 4N data bytes, least significant byte first per word;
  - then 1 checksum byte.
- Checksum: XOR of the header bytes and all data bytes. The trailer byte must equal it.
- States and transitions:
  - IDLE: `start` → HDR_LO. On that transition the word counter, lane counter and checksum clear, and `done`/`error` clear.
  - HDR_LO: handshake → HDR_HI.
  - HDR_HI: handshake → DATA if 1 ≤ N ≤ SIZE, otherwise → ERR.
  - DATA: each handshake shifts the byte into lane `lane_cnt` (0..3).
    - On lane 3: word k is registered, `instr_wr_en` pulses with `instr_wr_addr` = 4k, and k increments.
    - After word N-1 → CHK.
  - CHK: handshake → DONE if the checksum matches, else → ERR.
  - DONE: `cpu_reset`=0, `done`=1. `start` → HDR_LO.
  - ERR: `cpu_reset`=1, `error`=1. `start` → HDR_LO.
- `start` is ignored while `busy`.
- Words written before an error stay in memory. The processor never runs them because `cpu_reset` stays high.
- Width rules:
  - N is 16-bit unsigned, compared against SIZE at full width.
  - The word counter is LOGSIZE+1 bits so it can hold SIZE.
  - `instr_wr_addr` = {k[LOGSIZE-1:0], 2'b00}.

## Timing
- All outputs are registered.
- Reset values (take effect immediately, asynchronous):
  - state IDLE;
  - `cpu_reset`=1;
  - `byte_ready`, `instr_wr_en`, `busy`, `done`, `error` = 0;
  - `instr_in`=0, `instr_wr_addr`=0.
- `byte_ready` rises the cycle after `start`.
- `instr_wr_en` is high for exactly one cycle, the cycle after the lane-3 handshake. `instr_in` and `instr_wr_addr` are valid in that same cycle.
- `byte_ready` stays high during a write cycle, so a back-to-back stream sustains 1 byte/cycle with no stalls.
- `busy` is high from the cycle after `start` until the cycle state enters DONE/ERR.
- `done`/`error`/`cpu_reset` update the cycle after the deciding handshake (the CHK handshake, or the HDR_HI handshake for a bad header).
- Minimum load time: 4N+3 handshakes + 1 cycle.
- Gaps in `byte_valid` stall the FSM with no state change.
- A `start` in IDLE is not itself a handshake: any byte presented in that cycle is not consumed.
- Reset mid-operation aborts the load:
  - no further write pulse;
  - a write pulse already in flight is cleared asynchronously;
  - the next load restarts cleanly from `start`.

## Structure
- Package `instr_loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERR);
  - `HDR_BYTES`=2;
  - `BYTE_W`=8.
- One sub-module, `loader_word_assembler`, is natural. It holds:
  - the 4-lane byte shift register;
  - the 2-bit lane counter;
  - a `word_valid` pulse on lane-3 accept;
  - a `clear` input.
- The top level holds the FSM, the word counter, the checksum, and the output registers.

## Test plan
- Nominal load, SIZE=64, stream 02 00 93 00 50 00 13 01 A0 00 73:
  - writes (addr 0, 0x00500093) then (addr 4, 0x00A00113), one `instr_wr_en` pulse each, the cycle after the 4th and 8th data bytes;
  - then `done`=1, `cpu_reset`=0, `busy`=0.
- Bad header:
  - stream 00 00 → ERR after the 2nd byte: `error`=1, `cpu_reset`=1, no writes.
  - stream 41 00 (N=65) → same result.
- Checksum mismatch: the nominal stream with trailer 72 → both words written, then `error`=1, `done`=0, `cpu_reset`=1.
- Backpressure: the nominal stream with random 0–3 idle cycles on `byte_valid` → identical writes and result; no byte dropped or duplicated.
- Asynchronous reset after 6 data bytes of the nominal stream:
  - all outputs return to reset values immediately, `cpu_reset`=1;
  - a new `start` and the full stream → correct writes from addr 0.
- Start handling:
  - `start` pulsed mid-DATA → ignored; the load completes normally.
  - `start` in DONE → `cpu_reset`=1 and `done`=0 next cycle; a full SIZE=64 load writes the last word at addr 252.
